// File: rtl/seg7_defs.sv
// Shared seven-segment definitions: glyph codes, idle codes, scan FSM states
// and small select-code helpers used by the decoder and the display driver.
package seg7_defs;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex values 0..F
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // No segment lit (all a..g pins high on the active-low bus)
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Pin levels when nothing is driven / selected
  localparam logic [3:0] SEL_IDLE = 4'b1111;
  localparam logic [7:0] SEG_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  // True when exactly one active-low select bit is asserted
  function automatic logic sel_single(input logic [3:0] sel);
    return (sel == 4'b1110) || (sel == 4'b1101) ||
           (sel == 4'b1011) || (sel == 4'b0111);
  endfunction

  // Position index of a single-select code (0 for anything else)
  function automatic logic [1:0] sel_position(input logic [3:0] sel);
    logic [1:0] pos;
    case (sel)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup from an active-high seven-segment glyph to a hex value.
module seg7_glyph_decode
  import seg7_defs::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] value,
  output logic       is_valid,
  output logic       is_blank
);

  // Match the glyph against the sixteen hex shapes and the blank code
  always_comb begin
    value    = 4'h0;
    is_valid = 1'b1;
    is_blank = 1'b0;
    case (glyph)
      GLYPH_0:     value = 4'h0;
      GLYPH_1:     value = 4'h1;
      GLYPH_2:     value = 4'h2;
      GLYPH_3:     value = 4'h3;
      GLYPH_4:     value = 4'h4;
      GLYPH_5:     value = 4'h5;
      GLYPH_6:     value = 4'h6;
      GLYPH_7:     value = 4'h7;
      GLYPH_8:     value = 4'h8;
      GLYPH_9:     value = 4'h9;
      GLYPH_A:     value = 4'hA;
      GLYPH_B:     value = 4'hB;
      GLYPH_C:     value = 4'hC;
      GLYPH_D:     value = 4'hD;
      GLYPH_E:     value = 4'hE;
      GLYPH_F:     value = 4'hF;
      GLYPH_BLANK: begin
        is_valid = 1'b0;
        is_blank = 1'b1;
      end
      default:     is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Recovers per-position hex digits from a multiplexed, active-low
// seven-segment scan bus. A select code must be stable for SETTLE_CYCLES
// synchronized cycles before its segments are captured.
module segment_scan_decoder
  import seg7_defs::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] segments,
  input  logic [3:0] digit_select,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       pattern_error,
  output logic       select_error
);

  localparam logic [7:0] SETTLE_TARGET = 8'(SETTLE_CYCLES);

  logic [7:0]      seg_meta, seg_sync, seg_prev;
  logic [3:0]      sel_meta, sel_sync, sel_prev;
  scan_state_t     state, state_next;
  logic [7:0]      count, count_next;
  logic            capture;
  logic            sel_active, sel_change, any_change;
  logic            single;
  logic [1:0]      pos;
  logic [3:0]      cap_bits;
  logic [3:0]      mask;
  logic [3:0][3:0] digit_q;
  logic [3:0]      dec_value;
  logic            dec_valid, dec_blank;

  seg7_glyph_decode u_decode (
    .glyph    (~seg_sync[6:0]),
    .value    (dec_value),
    .is_valid (dec_valid),
    .is_blank (dec_blank)
  );

  assign sel_active = (sel_sync != SEL_IDLE);
  assign sel_change = (sel_sync != sel_prev);
  assign any_change = sel_change || (seg_sync != seg_prev);
  assign single     = sel_single(sel_sync);
  assign pos        = sel_position(sel_sync);
  assign cap_bits   = (capture && single) ? ~sel_sync : 4'b0000;

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

  // Two-flop synchronizer plus a one-cycle history used for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_meta <= SEG_IDLE;
      seg_sync <= SEG_IDLE;
      seg_prev <= SEG_IDLE;
      sel_meta <= SEL_IDLE;
      sel_sync <= SEL_IDLE;
      sel_prev <= SEL_IDLE;
    end else begin
      seg_meta <= segments;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      sel_meta <= digit_select;
      sel_sync <= sel_meta;
      sel_prev <= sel_sync;
    end
  end

  // Scan FSM state and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic; capture fires on the edge the counter reaches the target
  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_active) begin
          state_next = ST_SETTLE;
          count_next = 8'd1;
        end else begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (!sel_active) begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end else if (any_change) begin
          state_next = ST_SETTLE;
          count_next = 8'd1;
        end else if (count < SETTLE_TARGET) begin
          count_next = count + 8'd1;
        end else begin
          count_next = count;
        end
      end
      ST_HOLD: begin
        if (!sel_active) begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end else if (sel_change) begin
          state_next = ST_SETTLE;
          count_next = 8'd1;
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 8'd0;
      end
    endcase
    // A single-cycle target (SETTLE_CYCLES == 1) captures on the load edge
    if ((state_next == ST_SETTLE) && (count_next == SETTLE_TARGET)) begin
      state_next = ST_HOLD;
      capture    = 1'b1;
    end else begin
      capture    = 1'b0;
    end
  end

  // Update captured digits, the frame mask and the status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q       <= 16'h0000;
      dp            <= 4'b0000;
      digit_valid   <= 4'b0000;
      mask          <= 4'b0000;
      frame_done    <= 1'b0;
      pattern_error <= 1'b0;
      select_error  <= 1'b0;
    end else begin
      frame_done    <= (mask == 4'b1111);
      pattern_error <= 1'b0;
      select_error  <= 1'b0;
      // A completed frame clears the mask but keeps a coincident capture
      if (mask == 4'b1111) begin
        mask <= cap_bits;
      end else begin
        mask <= mask | cap_bits;
      end
      if (capture) begin
        if (single) begin
          if (dec_valid) begin
            digit_q[pos]     <= dec_value;
            dp[pos]          <= ~seg_sync[7];
            digit_valid[pos] <= 1'b1;
          end else if (dec_blank) begin
            dp[pos]          <= ~seg_sync[7];
            digit_valid[pos] <= 1'b0;
          end else begin
            digit_valid[pos] <= 1'b0;
            pattern_error    <= 1'b1;
          end
        end else begin
          select_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed self-checking bench for segment_scan_decoder with a scoreboard of
// expected register state and pulse counts per stimulus slot.
`timescale 1ns/1ps
module tb_segment_scan_decoder;

  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] segments = 8'hFF;
  logic [3:0] digit_select = 4'hF;
  logic [3:0] digit0, digit1, digit2, digit3, dp, digit_valid;
  logic       frame_done, pattern_error, select_error;

  segment_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .segments      (segments),
    .digit_select  (digit_select),
    .digit0        (digit0),
    .digit1        (digit1),
    .digit2        (digit2),
    .digit3        (digit3),
    .dp            (dp),
    .digit_valid   (digit_valid),
    .frame_done    (frame_done),
    .pattern_error (pattern_error),
    .select_error  (select_error)
  );

  always #16 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    int          fd;
    int          pe;
    int          se;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_dig [4];
  logic [3:0] m_dp, m_valid, m_mask;
  int checks = 0, failures = 0;
  int fd_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int fd_base, pe_base, se_base;

  // Count one-cycle status pulses away from the active edge
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (pattern_error === 1'b1) pe_cnt++;
    if (select_error === 1'b1) se_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pins(input int v, input logic lit);
    logic [6:0] g;
    g = glyph_tab[v];
    return {~lit, ~g};
  endfunction

  task automatic mark();
    fd_base = fd_cnt;
    pe_base = pe_cnt;
    se_base = se_cnt;
  endtask

  task automatic push_state(input int fd, input int pe, input int se);
    exp_t e;
    e.digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    e.dp = m_dp;
    e.valid = m_valid;
    e.fd = fd;
    e.pe = pe;
    e.se = se;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_dp = 4'b0000;
    m_valid = 4'b0000;
    m_mask = 4'b0000;
    push_state(0, 0, 0);
  endtask

  // Predict the effect of holding (sel, seg) long enough to settle
  task automatic model_slot(input logic [3:0] sel, input logic [7:0] seg);
    int zeros, pos, hit, fd, pe, se;
    logic [6:0] g;
    zeros = 0; pos = 0; fd = 0; pe = 0; se = 0;
    for (int i = 0; i < 4; i++) if (sel[i] == 1'b0) begin zeros++; pos = i; end
    if (zeros > 1) begin
      se = 1;
    end else if (zeros == 1) begin
      g = ~seg[6:0];
      hit = -1;
      for (int v = 0; v < 16; v++) if (glyph_tab[v] == g) hit = v;
      if (hit >= 0) begin
        m_dig[pos] = hit[3:0];
        m_dp[pos] = ~seg[7];
        m_valid[pos] = 1'b1;
      end else if (g == 7'h00) begin
        m_valid[pos] = 1'b0;
        m_dp[pos] = ~seg[7];
      end else begin
        m_valid[pos] = 1'b0;
        pe = 1;
      end
      m_mask[pos] = 1'b1;
      if (m_mask == 4'hF) begin
        fd = 1;
        m_mask = 4'b0000;
      end
    end
    push_state(fd, pe, se);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_digits"}, {16'h0000, digit3, digit2, digit1, digit0}, {16'h0000, e.digits});
      check({tag, "_dp"}, {28'h0, dp}, {28'h0, e.dp});
      check({tag, "_valid"}, {28'h0, digit_valid}, {28'h0, e.valid});
      check({tag, "_frame_done"}, fd_cnt - fd_base, e.fd);
      check({tag, "_pattern_error"}, pe_cnt - pe_base, e.pe);
      check({tag, "_select_error"}, se_cnt - se_base, e.se);
    end
  endtask

  task automatic run_slot(input logic [3:0] sel, input logic [7:0] seg, input int cycles,
                          input string tag);
    mark();
    model_slot(sel, seg);
    digit_select = sel;
    segments = seg;
    tick(cycles);
    compare(tag);
  endtask

  int scan_vals [4] = '{2, 10, 13, 15};
  int rec_vals  [4] = '{11, 14, 12, 5};

  initial begin
    // Reset state
    mark();
    rst = 1'b1;
    tick(4);
    model_reset();
    compare("reset");
    rst = 1'b0;
    tick(2);

    // Single capture latency: output changes exactly 2 + SETTLE cycles later
    mark();
    model_slot(4'b1110, 8'hF9);
    digit_select = 4'b1110;
    segments = 8'hF9;
    tick(SETTLE + 1);
    check("latency_early_valid", {31'h0, digit_valid[0]}, 32'h0);
    tick(1);
    check("latency_digit0", {28'h0, digit0}, 32'h1);
    check("latency_valid0", {31'h0, digit_valid[0]}, 32'h1);
    check("latency_dp0", {31'h0, dp[0]}, 32'h0);
    tick(2);
    compare("single");
    run_slot(4'hF, 8'hFF, 6, "idle");

    // Full scan of four positions, decimal point on position 2
    for (int p = 0; p < 4; p++) begin
      run_slot(~(4'b0001 << p), pins(scan_vals[p], (p == 2)), 20, "scan");
    end

    // Blank glyph, undecodable glyph, multi-select
    run_slot(4'b1101, 8'hFF, 20, "blank");
    run_slot(4'b1011, 8'hAA, 20, "bad_glyph");
    run_slot(4'b1100, pins(7, 1'b0), 20, "multi_sel");

    // Select toggling faster than the settle time never captures
    mark();
    model_slot(4'hF, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      digit_select = (i % 2 == 0) ? 4'b1110 : 4'b0111;
      segments = pins(8, 1'b0);
      tick(8);
    end
    digit_select = 4'hF;
    segments = 8'hFF;
    tick(4);
    compare("toggle");

    // Reset in the middle of a settle aborts the capture
    mark();
    digit_select = 4'b0111;
    segments = pins(5, 1'b0);
    tick(12);
    rst = 1'b1;
    digit_select = 4'hF;
    segments = 8'hFF;
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(24);
    compare("rst_abort");

    // Recovery: a fresh frame after reset, decimal point on position 0
    for (int p = 3; p >= 0; p--) begin
      run_slot(~(4'b0001 << p), pins(rec_vals[p], (p == 0)), 20, "recover");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
